// File: rtl/pipe_mem_stage.sv
// MEM stage: M register, word load/store bus handshake with timeout,
// pipeline freeze while an access is outstanding, and the W register.
module pipe_mem_stage #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ealu,
  input  logic [31:0] eb,
  input  logic [4:0]  ern,
  input  logic        ewreg,
  input  logic        em2reg,
  input  logic        ewmem,
  output logic        mstall,
  output logic [4:0]  mrn,
  output logic        mwreg,
  output logic        mm2reg,
  output logic [31:0] malu,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [4:0]  wrn,
  output logic        wwreg,
  output logic        wm2reg,
  output logic [31:0] wmo,
  output logic [31:0] walu,
  output logic        merr
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  mrn_q, mrn_d;
  logic        mwreg_q, mwreg_d;
  logic        mm2reg_q, mm2reg_d;
  logic        mwmem_q, mwmem_d;
  logic [31:0] malu_q, malu_d;
  logic [31:0] mb_q, mb_d;
  logic [4:0]  wrn_q, wrn_d;
  logic        wwreg_q, wwreg_d;
  logic        wm2reg_q, wm2reg_d;
  logic [31:0] wmo_q, wmo_d;
  logic [31:0] walu_q, walu_d;
  logic        merr_q, merr_d;

  logic in_wait, misal, timeout_hit, acked, e_op;

  always_comb begin
    in_wait     = (state_q == S_WAIT);
    misal       = (mm2reg_q | mwmem_q) & (malu_q[1:0] != 2'b00);
    acked       = in_wait & mem_ack;
    timeout_hit = in_wait & ~mem_ack & (cnt_q == 8'(TIMEOUT - 1));
    mstall      = in_wait & ~mem_ack & ~timeout_hit;
    e_op        = (em2reg | ewmem) & (ealu[1:0] == 2'b00);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mrn_d    = mrn_q;
    mwreg_d  = mwreg_q;
    mm2reg_d = mm2reg_q;
    mwmem_d  = mwmem_q;
    malu_d   = malu_q;
    mb_d     = mb_q;
    if (mstall) begin
      state_d = S_WAIT;
      cnt_d   = cnt_q + 8'd1;
    end else begin
      state_d  = e_op ? S_WAIT : S_IDLE;
      cnt_d    = 8'd0;
      mrn_d    = ern;
      mwreg_d  = ewreg;
      mm2reg_d = em2reg;
      mwmem_d  = ewmem;
      malu_d   = ealu;
      mb_d     = eb;
    end
  end

  // A stalled cycle loads a bubble so the held instruction writes back once.
  always_comb begin
    wrn_d    = 5'd0;
    wwreg_d  = 1'b0;
    wm2reg_d = 1'b0;
    wmo_d    = 32'd0;
    walu_d   = 32'd0;
    if (!mstall) begin
      wrn_d    = mrn_q;
      walu_d   = malu_q;
      wm2reg_d = mm2reg_q;
      wmo_d    = (acked & mm2reg_q) ? mem_rdata : 32'd0;
      wwreg_d  = mwreg_q & ~misal & ~timeout_hit;
    end
    merr_d = merr_q | misal | timeout_hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 8'd0;
      mrn_q    <= 5'd0;
      mwreg_q  <= 1'b0;
      mm2reg_q <= 1'b0;
      mwmem_q  <= 1'b0;
      malu_q   <= 32'd0;
      mb_q     <= 32'd0;
      wrn_q    <= 5'd0;
      wwreg_q  <= 1'b0;
      wm2reg_q <= 1'b0;
      wmo_q    <= 32'd0;
      walu_q   <= 32'd0;
      merr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mrn_q    <= mrn_d;
      mwreg_q  <= mwreg_d;
      mm2reg_q <= mm2reg_d;
      mwmem_q  <= mwmem_d;
      malu_q   <= malu_d;
      mb_q     <= mb_d;
      wrn_q    <= wrn_d;
      wwreg_q  <= wwreg_d;
      wm2reg_q <= wm2reg_d;
      wmo_q    <= wmo_d;
      walu_q   <= walu_d;
      merr_q   <= merr_d;
    end
  end

  always_comb begin
    mrn       = mrn_q;
    mwreg     = mwreg_q;
    mm2reg    = mm2reg_q;
    malu      = malu_q;
    mem_req   = in_wait;
    mem_we    = mwmem_q & in_wait;
    mem_addr  = malu_q;
    mem_wdata = mb_q;
    wrn       = wrn_q;
    wwreg     = wwreg_q;
    wm2reg    = wm2reg_q;
    wmo       = wmo_q;
    walu      = walu_q;
    merr      = merr_q;
  end

endmodule

// File: doc/pipe_mem_stage.md
Name: pipe_mem_stage

Overview:
- MEM stage of the five-stage pipelined CPU: the consumer end of the execute stage's result interface (ALU result, destination register, store data).
- Registers EXE outputs into the M register and issues word load/store transactions to a data-memory bus with a req/ack handshake.
- Freezes upstream stages while a transaction is outstanding and delivers results to the WB register.
- Exposes M-stage state to the forwarding/hazard unit.

Parameters:
- TIMEOUT, 255: maximum WAIT cycles without ack before the access is aborted (1..255).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- ealu  in  32  EXE result / memory address
- eb  in  32  store data
- ern  in  5  destination register
- ewreg  in  1  register write enable
- em2reg  in  1  load (result from memory)
- ewmem  in  1  store
- mstall  out  1  freeze PC/IF/ID/EXE registers
- mrn  out  5  M-stage destination (forwarding)
- mwreg  out  1  M-stage write enable (forwarding)
- mm2reg  out  1  M-stage is load (load-use hazard)
- malu  out  32  M-stage ALU result (forwarding)
- mem_req  out  1  bus request
- mem_we  out  1  bus write
- mem_addr  out  32  word address (= malu)
- mem_wdata  out  32  store data
- mem_rdata  in  32  load data, valid with mem_ack
- mem_ack  in  1  transaction complete
- wrn  out  5  WB destination
- wwreg  out  1  WB write enable
- wm2reg  out  1  WB select memory data
- wmo  out  32  loaded word
- walu  out  32  ALU result to WB
- merr  out  1  sticky error (misaligned or timeout)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset: all registered outputs 0, state IDLE, timeout counter 0, merr 0. Reset wins over every other event, including mid-WAIT; mem_req is 0 in the cycle after the reset edge.
- M register (mrn, mwreg, mm2reg, mwmem, malu, mb) loads E inputs on each edge where mstall = 0 and holds otherwise.
- Memory op: mm2reg | mwmem. Misaligned: memory op with malu[1:0] != 0.
- States: IDLE, WAIT.
  - Edge with mstall = 0 loading an aligned E memory op (em2reg | ewmem with ealu[1:0] = 0): enter WAIT, counter cleared.
  - Otherwise: enter IDLE.
- Handshake:
  - mem_req = (state == WAIT).
  - mem_we = mwmem & mem_req.
  - mem_addr and mem_wdata are held stable from the M register throughout WAIT.
  - mem_ack is sampled only in WAIT and ignored in IDLE.
- Stall: mstall = (state == WAIT) & ~mem_ack & ~timeout_hit.
  - Ack in the first WAIT cycle gives 0 stall cycles; ack in WAIT cycle k gives k-1 stall cycles.
- W register update, every edge:
  - mstall = 1: a bubble is loaded (wwreg = 0, wm2reg = 0), so no duplicate writeback occurs.
  - Otherwise: wrn = mrn, walu = malu, wm2reg = mm2reg, wmo = mem_rdata for an acked load and 0 in all other cases, wwreg = mwreg unless squashed.
- Misaligned access: no bus request and no stall. The instruction is squashed (wwreg = 0 in WB) and merr is set.
- Timeout: the counter increments each WAIT cycle without ack. timeout_hit = (counter == TIMEOUT-1) & ~mem_ack. On timeout_hit the access is abandoned, the instruction is squashed, merr is set, and the pipeline advances that cycle.
- Ack and timeout_hit in the same cycle: ack wins, normal completion.
- Stores: wwreg follows mwreg (normally 0); wmo = 0.
- Non-memory ops pass M to W in one cycle with no stall.
- merr clears only on reset.

Test Plan:
- ALU op: ealu = 0x00000010, ern = 5, ewreg = 1, no memory -> next edge mrn = 5, malu = 0x10; following edge wrn = 5, wwreg = 1, walu = 0x10; mstall never 1.
- Load with ack on 3rd WAIT cycle, mem_rdata = 0xDEADBEEF, addr 0x100 -> mem_req high 3 cycles with mem_addr = 0x100, mstall high 2 cycles, then wmo = 0xDEADBEEF, wm2reg = 1, wwreg = 1, with exactly one WB write.
- Store: addr 0x204, eb = 0x12345678, ack in first cycle -> mem_we = 1, mem_wdata = 0x12345678 for one cycle, 0 stall cycles, wwreg = 0.
- Misaligned load at 0x00000102 -> mem_req stays 0, mstall stays 0, wwreg = 0 for that instruction, merr = 1 until reset.
- TIMEOUT = 4, never ack -> mem_req high exactly 4 cycles, mstall high 3 cycles, instruction squashed, merr = 1, next instruction proceeds.
- Reset asserted on 2nd WAIT cycle of a load -> after the edge mem_req = 0, mstall = 0, all W/M outputs 0, merr = 0; a late mem_ack is ignored.
